// File: rtl/cu_pkg.sv
// Shared types and field positions for the multi-cycle control unit.
package cu_pkg;
    localparam int PC_W = 8;
    localparam int IW   = 32;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ALU  = 4'd1,
        OP_CMP  = 4'd2,
        OP_BR   = 4'd3,
        OP_JMP  = 4'd4,
        OP_HALT = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_HALT
    } state_e;

    localparam int OPC_LSB = 28;
    localparam int ULA_LSB = 24;
    localparam int RD_LSB  = 20;
    localparam int RA_LSB  = 16;
    localparam int RB_LSB  = 12;
    localparam int SEL_LSB = 10;
    localparam int IMM_LSB = 0;

    localparam int FLAG_LT = 0;
    localparam int FLAG_LE = 1;
    localparam int FLAG_EQ = 2;
    localparam int FLAG_GE = 3;
    localparam int FLAG_GT = 4;
endpackage

// File: rtl/cu_decode.sv
// Pure combinational split of the instruction register into opcode and fields.
// Unknown opcodes decode to NOP; reserved bits [9:8] are ignored.
module cu_decode
    import cu_pkg::*;
(
    input  logic [31:0] i_ir,
    output opcode_e     o_opcode,
    output logic [3:0]  o_ula,
    output logic [3:0]  o_rd,
    output logic [3:0]  o_ra,
    output logic [3:0]  o_rb,
    output logic [1:0]  o_sel,
    output logic [7:0]  o_imm
);
    logic w_unused_rsvd;

    always_comb begin
        o_opcode = OP_NOP;
        case (i_ir[OPC_LSB +: 4])
            OP_ALU, OP_CMP, OP_BR, OP_JMP, OP_HALT: o_opcode = opcode_e'(i_ir[OPC_LSB +: 4]);
            default:                                o_opcode = OP_NOP;
        endcase
    end

    assign o_ula         = i_ir[ULA_LSB +: 4];
    assign o_rd          = i_ir[RD_LSB +: 4];
    assign o_ra          = i_ir[RA_LSB +: 4];
    assign o_rb          = i_ir[RB_LSB +: 4];
    assign o_sel         = i_ir[SEL_LSB +: 2];
    assign o_imm         = i_ir[IMM_LSB +: 8];
    assign w_unused_rsvd = ^i_ir[9:8];
endmodule

// File: rtl/control_unit_sc.sv
// Multi-cycle fetch/decode/execute control unit driving the 8-bit datapath selects.
// Latency 3 cycles per instruction plus memory wait; FETCH stalls until instr_valid.
// Optional CU_FLAGS_REG_EN: CMP latches comparator flags and BR tests the latched copy.
module control_unit_sc
    import cu_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int IW   = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            instr_req,
    output logic [PC_W-1:0] instr_addr,
    input  logic            instr_valid,
    input  logic [IW-1:0]   instr_data,
    input  logic [4:0]      outComparator,
    output logic [7:0]      CTE,
    output logic [3:0]      SRD,
    output logic [3:0]      SBA,
    output logic [3:0]      SBB,
    output logic [3:0]      SULA,
    output logic [1:0]      selMuxCTE,
    output logic            LE,
    output logic [PC_W-1:0] pc,
    output logic            halted
);
    state_e          r_state;
    logic [PC_W-1:0] r_pc;
    logic [IW-1:0]   r_ir;

    opcode_e    w_op;
    logic [3:0] w_ula, w_rd, w_ra, w_rb;
    logic [1:0] w_sel;
    logic [7:0] w_imm;
    logic [4:0] w_flags;
    logic [7:0] w_flags_ext;
    logic       w_taken;
    logic       w_active;

    cu_decode u_decode (
        .i_ir     (r_ir),
        .o_opcode (w_op),
        .o_ula    (w_ula),
        .o_rd     (w_rd),
        .o_ra     (w_ra),
        .o_rb     (w_rb),
        .o_sel    (w_sel),
        .o_imm    (w_imm)
    );

`ifdef CU_FLAGS_REG_EN
    logic [4:0] r_flags;
    assign w_flags = r_flags;
`else
    assign w_flags = outComparator;
`endif

    // Flag indices 5..7 read the zero padding, so such branches never take.
    assign w_flags_ext = {3'b000, w_flags};
    assign w_taken     = (w_op == OP_BR) && w_flags_ext[w_rd[2:0]];
    assign w_active    = (r_state == ST_DECODE) || (r_state == ST_EXECUTE);

    always_comb begin
        CTE       = '0;
        SRD       = '0;
        SBA       = '0;
        SBB       = '0;
        SULA      = '0;
        selMuxCTE = '0;
        if (w_active) begin
            case (w_op)
                OP_ALU: begin
                    SRD = w_rd; SBA = w_ra; SBB = w_rb; SULA = w_ula;
                    selMuxCTE = w_sel; CTE = w_imm;
                end
                OP_CMP: begin
                    SBA = w_ra; SBB = w_rb; SULA = w_ula;
                    selMuxCTE = w_sel; CTE = w_imm;
                end
                OP_BR: begin
                    SBA = w_ra; SBB = w_rb;
                    selMuxCTE = w_sel; CTE = w_imm;
                end
                default: ;
            endcase
        end
    end

    // rst masks the write enable so an interrupted ALU never lands in the bank.
    assign LE         = (r_state == ST_EXECUTE) && (w_op == OP_ALU) && !rst;
    assign instr_req  = (r_state == ST_FETCH) && !rst;
    assign halted     = (r_state == ST_HALT);
    assign instr_addr = r_pc;
    assign pc         = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RESET;
            r_pc    <= '0;
            r_ir    <= '0;
`ifdef CU_FLAGS_REG_EN
            r_flags <= '0;
`endif
        end else begin
            case (r_state)
                ST_RESET:   r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (instr_valid) begin
                        r_ir    <= instr_data;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE:  r_state <= ST_EXECUTE;
                ST_EXECUTE: begin
                    if (w_op == OP_HALT) begin
                        r_state <= ST_HALT;
                    end else begin
                        r_state <= ST_FETCH;
                        r_pc    <= ((w_op == OP_JMP) || w_taken) ? PC_W'(w_imm) : r_pc + PC_W'(1);
                    end
`ifdef CU_FLAGS_REG_EN
                    if (w_op == OP_CMP) r_flags <= outComparator;
`endif
                end
                ST_HALT:    r_state <= ST_HALT;
                default:    r_state <= ST_RESET;
            endcase
        end
    end
endmodule

// File: tb/tb_control_unit_sc.sv
// Directed + randomized bench for control_unit_sc against an instruction-level reference model.
module tb_control_unit_sc;
    logic       clk = 1'b0;
    logic       rst;
    logic       instr_req;
    logic [7:0] instr_addr;
    logic       instr_valid;
    logic [31:0] instr_data;
    logic [4:0] outComparator;
    logic [7:0] CTE;
    logic [3:0] SRD, SBA, SBB, SULA;
    logic [1:0] selMuxCTE;
    logic       LE;
    logic [7:0] pc;
    logic       halted;

    int n_checks = 0;
    int n_err    = 0;

    // Architectural reference state
    int       m_pc     = 0;
    bit       m_halted = 0;
    bit [4:0] m_flags  = '0;

    control_unit_sc dut (
        .clk           (clk),
        .rst           (rst),
        .instr_req     (instr_req),
        .instr_addr    (instr_addr),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .outComparator (outComparator),
        .CTE           (CTE),
        .SRD           (SRD),
        .SBA           (SBA),
        .SBB           (SBB),
        .SULA          (SULA),
        .selMuxCTE     (selMuxCTE),
        .LE            (LE),
        .pc            (pc),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [26:0] ctrl_obs();
        return {CTE, SRD, SBA, SBB, SULA, selMuxCTE, LE};
    endfunction

    // Expected datapath controls while an instruction is in DECODE (exec=0) or EXECUTE (exec=1).
    function automatic logic [26:0] ctrl_exp(input logic [31:0] ins, input bit exec);
        int  op;
        bit  alu, cmp, br;
        op  = int'(ins[31:28]);
        alu = (op == 1);
        cmp = (op == 2);
        br  = (op == 3);
        return {(alu || cmp || br) ? ins[7:0]   : 8'h00,
                alu                ? ins[23:20] : 4'h0,
                (alu || cmp || br) ? ins[19:16] : 4'h0,
                (alu || cmp || br) ? ins[15:12] : 4'h0,
                (alu || cmp)       ? ins[27:24] : 4'h0,
                (alu || cmp || br) ? ins[11:10] : 2'b00,
                exec && alu};
    endfunction

    task automatic model_exec(input logic [31:0] ins, input logic [4:0] cmp);
        int       op, idx;
        bit [4:0] fl;
        bit       taken;
        op  = int'(ins[31:28]);
        idx = int'(ins[22:20]);
`ifdef CU_FLAGS_REG_EN
        fl = m_flags;
        if (op == 2) m_flags = cmp;
`else
        fl = cmp;
`endif
        taken = (op == 3) && (idx <= 4) && (fl[idx] == 1'b1);
        if (op == 15)             m_halted = 1;
        else if (op == 4 || taken) m_pc = int'(ins[7:0]);
        else                      m_pc = (m_pc + 1) % 256;
    endtask

    task automatic model_reset();
        m_pc = 0; m_halted = 0; m_flags = '0;
    endtask

    // Starts and ends 1 time unit after a rising edge with the DUT in FETCH.
    task automatic run_instr(input logic [31:0] ins, input int wait_n, input logic [4:0] cmp, input bit abort);
        logic [31:0] r;
        outComparator = cmp;
        for (int i = 0; i < wait_n; i++) begin
            #1;
            check("wait_req", instr_req, 1);
            check("wait_ctrl", ctrl_obs(), 0);
            check("wait_pc", pc, m_pc);
            tick();
        end
        instr_valid = 1'b1;
        instr_data  = ins;
        #1;
        check("fetch_req", instr_req, 1);
        check("fetch_addr", instr_addr, m_pc);
        tick();
        r = $urandom;
        instr_valid = r[0];
        instr_data  = $urandom;
        #1;
        check("dec_req", instr_req, 0);
        check("dec_ctrl", ctrl_obs(), ctrl_exp(ins, 0));
        tick();
        if (abort) begin
            rst = 1'b1;
            #1;
            check("abort_le", LE, 0);
            check("abort_ctrl", ctrl_obs(), ctrl_exp(ins, 0));
            tick();
            model_reset();
            instr_valid = 1'b0;
            #1;
            check("abort_pc", pc, 0);
            check("abort_req", instr_req, 0);
            check("abort_ctrl0", ctrl_obs(), 0);
            rst = 1'b0;
            #1;
            check("abort_rel_req", instr_req, 0);
            tick();
        end else begin
            #1;
            check("exe_ctrl", ctrl_obs(), ctrl_exp(ins, 1));
            model_exec(ins, cmp);
            tick();
            instr_valid = 1'b0;
            #1;
            check("post_pc", pc, m_pc);
            check("post_halted", halted, m_halted);
            check("post_req", instr_req, !m_halted);
            check("post_ctrl", ctrl_obs(), 0);
        end
    endtask

    initial begin
        int          ops[7];
        logic [31:0] r;
        logic [31:0] ins;
        ops = '{0, 1, 2, 3, 4, 5, 9};

        // Reset held two cycles with a valid instruction presented
        rst = 1'b1; instr_valid = 1'b1; instr_data = 32'h1320_1000; outComparator = '0;
        tick();
        tick();
        #1;
        check("rst_pc", pc, 0);
        check("rst_req", instr_req, 0);
        check("rst_ctrl", ctrl_obs(), 0);
        check("rst_halted", halted, 0);
        rst = 1'b0; instr_valid = 1'b0;
        #1;
        check("rel_req0", instr_req, 0);
        tick();
        check("rel_req1", instr_req, 1);
        model_reset();

        // ALU ula=3 rd=2 ra=0 rb=1, immediate valid
        run_instr(32'h1320_1000, 0, 5'b00000, 0);
        check("alu_pc", pc, 1);
        // Memory wait of 4 cycles
        run_instr(32'h1571_2C33, 4, 5'b00000, 0);

        // Branch on eq, taken then not taken
        run_instr(32'h2034_0000, 0, 5'b01110, 0);
        run_instr(32'h3020_0040, 1, 5'b01110, 0);
        check("br_taken_pc", pc, 8'h40);
        run_instr(32'h2034_0000, 0, 5'b00011, 0);
        run_instr(32'h3020_0040, 0, 5'b00011, 0);
        check("br_not_taken_pc", pc, 8'h42);
        // Out-of-range flag index never takes
        run_instr(32'h2000_0000, 0, 5'b11111, 0);
        run_instr(32'h3050_0010, 0, 5'b11111, 0);
        check("br_idx5_pc", pc, 8'h44);

        // Randomized instruction stream
        for (int k = 0; k < 40; k++) begin
            r   = $urandom;
            ins = {4'(ops[$urandom_range(0, 6)]), r[27:0]};
            run_instr(ins, $urandom_range(0, 3), 5'($urandom), 0);
        end

        // pc wrap 0xFF -> 0x00
        run_instr(32'h4000_00FF, 0, 5'b00000, 0);
        check("jmp_ff_pc", pc, 8'hFF);
        run_instr(32'h0000_0000, 0, 5'b00000, 0);
        check("wrap_pc", pc, 8'h00);

        // Reset arriving during EXECUTE of an ALU
        run_instr(32'h1F21_3000, 0, 5'b00000, 1);
        check("abort_fetch_req", instr_req, 1);

        // HALT then absorbing state
        run_instr(32'h1120_1000, 2, 5'b00000, 0);
        run_instr(32'hF000_0000, 0, 5'b00000, 0);
        for (int i = 0; i < 5; i++) begin
            instr_valid = 1'b1;
            instr_data  = 32'h4000_0077;
            tick();
            check("halt_pc", pc, m_pc);
            check("halt_flag", halted, 1);
            check("halt_req", instr_req, 0);
        end
        rst = 1'b1; instr_valid = 1'b0;
        tick();
        model_reset();
        check("halt_rst", halted, 0);
        rst = 1'b0;
        tick();
        run_instr(32'h1320_1000, 0, 5'b00000, 0);
        check("recover_pc", pc, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
